// File: rtl/mmr_trigger_bank.sv
// mmr_trigger_bank: slave-side owner of an N x WIDTH trigger status register bank.
// Hardware event pulses set sticky TSR bits and the MMR master clears them with
// write-1-to-clear pulses. The bank also tracks lost events (a set on an already
// set bit that is not being cleared in the same cycle) through a sticky per-channel
// overflow flag and a saturating per-channel miss counter. It drives one aggregated,
// registered interrupt.
//
// Optional feature macro: MMR_TRIGGER_COALESCE_EN. When it is defined, irq comes from
// a coalescing FSM (IDLE/ARMED/FIRE) that waits for an event-count threshold or a
// timeout before it raises irq. When it is undefined, irq is pending delayed by one
// register stage, and coalesce_threshold and coalesce_timeout are ignored.
//
// Ports:
//   clock              system clock, rising edge
//   reset              synchronous active-high reset
//   set_pulses         [N][WIDTH] one-cycle event pulses
//   tsr                [N][WIDTH] registered sticky status bits
//   tsr_invpulses      [N][WIDTH] write-1-to-clear pulses
//   irq_enable         [N][WIDTH] per-bit interrupt enable
//   overflow           [N] sticky lost-event flag per channel
//   overflow_clear     [N] clears overflow[c] and miss_count[c]
//   miss_count         [N][MISS_WIDTH] saturating lost-event count
//   irq                aggregated level interrupt, registered
//   coalesce_threshold events needed before irq (feature only)
//   coalesce_timeout   cycles before a forced irq, 0 disables the timeout (feature only)
module mmr_trigger_bank #(
  parameter int unsigned N          = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MISS_WIDTH = 8,
  parameter int unsigned TMO_WIDTH  = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N-1:0][WIDTH-1:0]          set_pulses,
  output logic [N-1:0][WIDTH-1:0]          tsr,
  input  logic [N-1:0][WIDTH-1:0]          tsr_invpulses,
  input  logic [N-1:0][WIDTH-1:0]          irq_enable,
  output logic [N-1:0]                     overflow,
  input  logic [N-1:0]                     overflow_clear,
  output logic [N-1:0][MISS_WIDTH-1:0]     miss_count,
  output logic                             irq,
  input  logic [MISS_WIDTH-1:0]            coalesce_threshold,
  input  logic [TMO_WIDTH-1:0]             coalesce_timeout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = MISS_WIDTH + CNT_W;
  localparam logic [MISS_WIDTH-1:0] MISS_MAX = '1;

  logic [N-1:0][WIDTH-1:0]      tsr_q, tsr_d, lost;
  logic [N-1:0]                 ovf_q, ovf_d;
  logic [N-1:0][MISS_WIDTH-1:0] miss_q, miss_d;
  logic [N-1:0][CNT_W-1:0]      lost_cnt;
  logic [N-1:0][SUM_W-1:0]      miss_sum;
  logic                         pending;
  logic                         irq_q, irq_d;

  // A set on a bit that is being cleared in the same cycle is a fresh event, not a loss.
  always_comb begin
    lost     = set_pulses & tsr_q & ~tsr_invpulses;
    tsr_d    = set_pulses | (tsr_q & ~tsr_invpulses);
    lost_cnt = '0;
    for (int unsigned c = 0; c < N; c++) begin
      for (int unsigned b = 0; b < WIDTH; b++) begin
        lost_cnt[c] = lost_cnt[c] + CNT_W'(lost[c][b]);
      end
    end
  end

  // overflow_clear applies first, then the events lost in this cycle are counted.
  always_comb begin
    ovf_d    = '0;
    miss_d   = '0;
    miss_sum = '0;
    for (int unsigned c = 0; c < N; c++) begin
      ovf_d[c]    = (ovf_q[c] & ~overflow_clear[c]) | (|lost[c]);
      miss_sum[c] = (overflow_clear[c] ? SUM_W'(0) : SUM_W'(miss_q[c])) + SUM_W'(lost_cnt[c]);
      miss_d[c]   = (miss_sum[c] > SUM_W'(MISS_MAX)) ? MISS_MAX : MISS_WIDTH'(miss_sum[c]);
    end
  end

  assign pending = |(tsr_q & irq_enable);

`ifdef MMR_TRIGGER_COALESCE_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2
  } state_e;

  localparam int unsigned RISE_W = $clog2(N * WIDTH + 1);
  localparam int unsigned EC_W   = MISS_WIDTH + RISE_W;
  localparam logic [TMO_WIDTH-1:0] TM_MAX = '1;

  state_e                   state_q, state_d;
  logic [MISS_WIDTH-1:0]    ec_q, ec_d;
  logic [TMO_WIDTH-1:0]     tm_q, tm_d, tm_inc;
  logic [N-1:0][WIDTH-1:0]  rise;
  logic [RISE_W-1:0]        n_rise;
  logic [EC_W-1:0]          ec_sum;
  logic                     fire;

  // Only enabled bits going from 0 to 1 count as new interrupt-worthy events.
  always_comb begin
    rise   = set_pulses & ~tsr_q & irq_enable;
    n_rise = '0;
    for (int unsigned c = 0; c < N; c++) begin
      for (int unsigned b = 0; b < WIDTH; b++) begin
        n_rise = n_rise + RISE_W'(rise[c][b]);
      end
    end
  end

  // Coalescing next-state logic. ec is zero in IDLE, so one saturating sum serves arming and accumulation.
  always_comb begin
    state_d = state_q;
    ec_d    = ec_q;
    tm_d    = tm_q;
    ec_sum  = EC_W'(ec_q) + EC_W'(n_rise);
    tm_inc  = (tm_q == TM_MAX) ? tm_q : tm_q + TMO_WIDTH'(1);
    fire    = (ec_q >= coalesce_threshold) ||
              ((coalesce_timeout != '0) && (tm_inc == coalesce_timeout));
    case (state_q)
      ST_IDLE: begin
        ec_d = '0;
        tm_d = '0;
        if (n_rise != '0) begin
          state_d = ST_ARMED;
          ec_d    = (ec_sum > EC_W'(MISS_MAX)) ? MISS_MAX : MISS_WIDTH'(ec_sum);
        end
      end
      ST_ARMED: begin
        if (!pending) begin
          state_d = ST_IDLE;
          ec_d    = '0;
          tm_d    = '0;
        end else if (fire) begin
          state_d = ST_FIRE;
        end else begin
          ec_d = (ec_sum > EC_W'(MISS_MAX)) ? MISS_MAX : MISS_WIDTH'(ec_sum);
          tm_d = tm_inc;
        end
      end
      ST_FIRE: begin
        if (!pending) begin
          state_d = ST_IDLE;
          ec_d    = '0;
          tm_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ec_d    = '0;
        tm_d    = '0;
      end
    endcase
    irq_d = (state_d == ST_FIRE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ec_q    <= '0;
      tm_q    <= '0;
    end else begin
      state_q <= state_d;
      ec_q    <= ec_d;
      tm_q    <= tm_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{coalesce_threshold, coalesce_timeout};

  always_comb begin
    irq_d = pending;
  end
`endif

  // Bank state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      tsr_q  <= '0;
      ovf_q  <= '0;
      miss_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      tsr_q  <= tsr_d;
      ovf_q  <= ovf_d;
      miss_q <= miss_d;
      irq_q  <= irq_d;
    end
  end

  assign tsr        = tsr_q;
  assign overflow   = ovf_q;
  assign miss_count = miss_q;
  assign irq        = irq_q;

endmodule

// File: doc/mmr_trigger_bank.md
Name: mmr_trigger_bank

Overview:
- Slave-side owner of an N-channel, WIDTH-bit trigger status register (TSR) bank.
- Hardware event pulses set sticky TSR bits; the MMR master clears them with write-1-to-clear inverse pulses.
- Adds per-bit interrupt enables, per-channel overflow detection, saturating miss counters and an aggregated interrupt.
- Sits between event-producing datapath blocks and the MMR register file; `tsr`/`tsr_invpulses` connect to the trigger interface slave modport.

Parameters:
- N, 4, number of channels (1..32)
- WIDTH, 32, bits per channel
- MISS_WIDTH, 8, width of per-channel saturating miss counter
- TMO_WIDTH, 16, coalescing timeout counter width (used only with the optional feature)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- set_pulses  in  [N][WIDTH]  one-cycle event pulses; set the matching TSR bits
- tsr  out  [N][WIDTH]  sticky status bits (registered)
- tsr_invpulses  in  [N][WIDTH]  write-1-to-clear pulses from the MMR master
- irq_enable  in  [N][WIDTH]  per-bit interrupt enable
- overflow  out  [N]  sticky per-channel overflow flag
- overflow_clear  in  [N]  pulse; clears overflow[c] and miss_count[c]
- miss_count  out  [N][MISS_WIDTH]  saturating count of lost events per channel
- irq  out  1  aggregated interrupt, level, registered
- coalesce_threshold  in  MISS_WIDTH  events before irq (feature only; otherwise ignored)
- coalesce_timeout  in  TMO_WIDTH  cycles before forced irq (feature only; otherwise ignored)

Behaviour:
- Reset (synchronous, active-high, `reset`) clears tsr, overflow, miss_count, irq, the coalescing FSM and all counters. Reset asserted mid-operation discards pending events in that cycle.
- TSR update per bit: `tsr_next = set | (tsr & ~invpulse)`. Set and clear on the same bit in the same cycle leave the bit at 1. The clear acknowledges the old event and the new event is latched. This case is not an overflow.
- Latency: set_pulse at cycle t appears on tsr at t+1.
- Lost event: set_pulse=1, tsr=1 and invpulse=0 on the same bit.
- Any lost event in channel c sets overflow[c] at t+1.
- miss_count[c] adds the popcount of lost bits in that cycle and saturates at 2^MISS_WIDTH-1 (no wrap).
- overflow_clear[c] coinciding with a new lost event: the clear takes effect first, then the new event is counted. Result: overflow[c]=1, miss_count[c]=popcount.
- pending = OR over all channels/bits of `(tsr & irq_enable)`, evaluated on registered tsr.
- Without the optional feature: `irq` is registered pending, 1-cycle latency from tsr, so 2 cycles from set_pulse.
- irq_enable changes affect only irq; they never alter tsr.

Optional Feature:
- Macro: MMR_TRIGGER_COALESCE_EN.
- When defined, irq is driven by a coalescing FSM with these states:
  - IDLE: irq=0, event counter ec=0, timer tm=0. An enabled rising event (an enabled set_pulse bit whose tsr bit was 0) goes to ARMED with ec=number of such bits.
  - ARMED: ec accumulates enabled rising events (saturating). tm increments each cycle.
    - Go to FIRE when ec >= coalesce_threshold or tm == coalesce_timeout.
    - Go to IDLE when pending drops to 0 first.
    - coalesce_threshold <= 1 fires on the first event (FIRE on the cycle after the arming cycle).
    - coalesce_timeout=0 disables the timeout.
  - FIRE: irq=1. Go to IDLE when pending==0. ec and tm are cleared on exit.
- When not defined: FSM, counters, coalesce_threshold and coalesce_timeout are absent or ignored, and irq follows pending as above.

Test Plan:
- Reset then set_pulses[2]=0x0000_0005 for one cycle -> tsr[2]=0x5 next cycle, overflow=0, miss_count all 0; irq_enable[2]=0x1 -> irq=1 two cycles after the pulse.
- With tsr[0]=0x1, same-cycle set_pulses[0]=0x1 and tsr_invpulses[0]=0x1 -> tsr[0] stays 0x1, overflow[0]=0, miss_count[0]=0.
- With tsr[1]=0xF, set_pulses[1]=0xF repeated 70 times (MISS_WIDTH=8) -> miss_count[1]=255 (saturated), overflow[1]=1; overflow_clear[1] -> both 0 next cycle.
- tsr_invpulses[3]=0xFFFF_FFFF while tsr[3]=0x3 and the only enabled bits -> tsr[3]=0 next cycle, irq drops 1 cycle later.
- MMR_TRIGGER_COALESCE_EN, threshold=3, timeout=0: three enabled single-bit events on cycles 0, 5, 9 -> irq stays 0 until threshold reached, then 1; clearing all bits -> irq=0, FSM back in IDLE.
- MMR_TRIGGER_COALESCE_EN, threshold=10, timeout=20: one enabled event -> irq asserts 20 cycles after arming. Reset asserted while in FIRE -> irq=0 and tsr=0 on the next cycle.
